issue_payload: RTL and testbench

- Sits beside inst_sched, between dispatch and execute.
- Owns the IQ slot IDs. Hands a free iq_id to dispatch, stores that instruction's non-scheduling payload (opcode, immediate, PC, misc) at that ID, and returns the ID to the free list when the scheduler issues it.
- On issue, reads the payload and registers it toward the execute stage, paired with the issue.

---
 rtl/issue_payload_pkg.sv | 17 +
 rtl/issue_payload_iq_free_list.sv | 75 +++++++
 rtl/issue_payload.sv | 84 ++++++++
 tb/tb_issue_payload.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_payload_pkg.sv
// Shared types and constants for the issue payload slice.
// Payload layout and IQ sizing used by dispatch and execute.
package issue_payload_pkg;

  localparam int IqDepth = 4;
  localparam int IqW     = $clog2(IqDepth);

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [3:0]  flags;
  } IssuePayload_t;

  localparam int PayloadW = $bits(IssuePayload_t);

endpackage

// File: rtl/issue_payload_iq_free_list.sv
// Circular FIFO of free IQ slot IDs.
// Re-initialised to 0..DEPTH-1 on reset or flush.
module iq_free_list
  import issue_payload_pkg::*;
#(
  parameter  int DEPTH = IqDepth,
  localparam int W     = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         init,
  input  logic         alloc,
  input  logic         free,
  input  logic [W-1:0] free_id,
  output logic [W-1:0] head_id,
  output logic [W:0]   cnt
);

  localparam logic [W:0] Full = (W+1)'(DEPTH);

  logic [W-1:0] fl_q [DEPTH];
  logic [W-1:0] fl_d [DEPTH];
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [W:0]   cnt_q, cnt_d;
  logic         free_ok;

  assign head_id = fl_q[head_q];
  assign cnt     = cnt_q;
  assign free_ok = free && (cnt_q != Full);

  always_comb begin
    fl_d   = fl_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (init) begin
      for (int i = 0; i < DEPTH; i++)
        fl_d[i] = W'(i);
      head_d = '0;
      tail_d = '0;
      cnt_d  = Full;
    end else begin
      if (alloc)
        head_d = head_q + 1'b1;
      if (free_ok) begin
        fl_d[tail_q] = free_id;
        tail_d       = tail_q + 1'b1;
      end
      cnt_d = cnt_q - (W+1)'(alloc) + (W+1)'(free_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++)
        fl_q[i] <= W'(i);
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= Full;
    end else begin
      fl_q   <= fl_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // A free with every ID already home is a scheduler bug; it is dropped.
  a_no_overfree: assert property (
    @(posedge clk) disable iff (!reset_)
    !(free && !init && cnt_q == Full)
  ) else $warning("iq_free_list: free with no outstanding id dropped");

endmodule

// File: rtl/issue_payload.sv
// IQ slot ID owner and payload store beside the scheduler.
// Grants IDs at dispatch, stores payload, registers it toward execute.
module issue_payload
  import issue_payload_pkg::*;
#(
  parameter  int IQ_DEPTH = IqDepth,
  parameter  int PAYLOAD  = PayloadW,
  localparam int IQ       = $clog2(IQ_DEPTH)
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               flush_,
  input  logic               dec_req_,
  input  logic [PAYLOAD-1:0] dec_payload,
  output logic [IQ-1:0]      dec_iq_id,
  output logic               add_entry_,
  output logic               iq_full,
  output logic [IQ:0]        free_cnt,
  input  logic               issue_e_,
  input  logic [IQ-1:0]      issue_iq_id,
  output logic               exe_e_,
  output logic [IQ-1:0]      exe_iq_id,
  output logic [PAYLOAD-1:0] exe_payload
);

  logic               alloc;
  logic               issue_ok;
  logic [PAYLOAD-1:0] pl_q [IQ_DEPTH];

  logic               exe_e_q, exe_e_d;
  logic [IQ-1:0]      exe_id_q, exe_id_d;
  logic [PAYLOAD-1:0] exe_pl_q, exe_pl_d;

  assign iq_full    = (free_cnt == '0);
  assign add_entry_ = dec_req_ | iq_full | !flush_ | !reset_;
  assign alloc      = !add_entry_;
  assign issue_ok   = !issue_e_ && flush_;

  iq_free_list #(
    .DEPTH(IQ_DEPTH)
  ) u_free_list (
    .clk     (clk),
    .reset_  (reset_),
    .init    (!flush_),
    .alloc   (alloc),
    .free    (issue_ok),
    .free_id (issue_iq_id),
    .head_id (dec_iq_id),
    .cnt     (free_cnt)
  );

  // Payload array is not reset; every slot is written before it issues.
  always_ff @(posedge clk) begin
    if (alloc)
      pl_q[dec_iq_id] <= dec_payload;
  end

  always_comb begin
    exe_e_d  = !issue_ok;
    exe_id_d = exe_id_q;
    exe_pl_d = exe_pl_q;
    if (issue_ok) begin
      exe_id_d = issue_iq_id;
      exe_pl_d = pl_q[issue_iq_id];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      exe_e_q  <= 1'b1;
      exe_id_q <= '0;
      exe_pl_q <= '0;
    end else begin
      exe_e_q  <= exe_e_d;
      exe_id_q <= exe_id_d;
      exe_pl_q <= exe_pl_d;
    end
  end

  assign exe_e_      = exe_e_q;
  assign exe_iq_id   = exe_id_q;
  assign exe_payload = exe_pl_q;

endmodule

// File: tb/tb_issue_payload.sv
// Self-checking bench for issue_payload with a queue-based model.
module tb_issue_payload;
  import issue_payload_pkg::*;

  localparam int D  = 4;
  localparam int W  = 2;
  localparam int PW = PayloadW;

  logic          clk = 1'b0;
  logic          reset_ = 1'b0;
  logic          flush_ = 1'b1;
  logic          dec_req_ = 1'b1;
  logic [PW-1:0] dec_payload = '0;
  logic [W-1:0]  dec_iq_id;
  logic          add_entry_;
  logic          iq_full;
  logic [W:0]    free_cnt;
  logic          issue_e_ = 1'b1;
  logic [W-1:0]  issue_iq_id = '0;
  logic          exe_e_;
  logic [W-1:0]  exe_iq_id;
  logic [PW-1:0] exe_payload;

  int n_cmp = 0;
  int n_bad = 0;

  int            fq[$];
  logic [PW-1:0] mpl [D];
  logic          me_e = 1'b1;
  int            me_id = 0;
  logic [PW-1:0] me_pl = '0;

  always #5 clk = ~clk;

  issue_payload dut (
    .clk         (clk),
    .reset_      (reset_),
    .flush_      (flush_),
    .dec_req_    (dec_req_),
    .dec_payload (dec_payload),
    .dec_iq_id   (dec_iq_id),
    .add_entry_  (add_entry_),
    .iq_full     (iq_full),
    .free_cnt    (free_cnt),
    .issue_e_    (issue_e_),
    .issue_iq_id (issue_iq_id),
    .exe_e_      (exe_e_),
    .exe_iq_id   (exe_iq_id),
    .exe_payload (exe_payload)
  );

  function automatic logic exp_add_n();
    return !(reset_ && flush_ && !dec_req_ && fq.size() > 0);
  endfunction

  task automatic model_update();
    int pre;
    if (!reset_ || !flush_) begin
      fq = {0, 1, 2, 3};
      me_e = 1'b1;
      if (!reset_) begin
        me_id = 0;
        me_pl = '0;
      end
    end else begin
      pre = fq.size();
      if (!issue_e_) begin
        me_e  = 1'b0;
        me_id = int'(issue_iq_id);
        me_pl = mpl[issue_iq_id];
      end else begin
        me_e = 1'b1;
      end
      if (!dec_req_ && pre > 0) begin
        mpl[fq[0]] = dec_payload;
        void'(fq.pop_front());
      end
      if (!issue_e_ && pre < D)
        fq.push_back(int'(issue_iq_id));
    end
  endtask

  task automatic drive(input logic rs, input logic fl, input logic rq,
                       input logic [PW-1:0] p, input logic is,
                       input int iid);
    reset_      = rs;
    flush_      = fl;
    dec_req_    = rq;
    dec_payload = p;
    issue_e_    = is;
    issue_iq_id = W'(iid);
    #1;
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    drive(0, 1, 1, '0, 1, 0);
    clk_step();
  endtask

  task automatic test_reset();
    drive(0, 1, 0, PW'(32'h77), 1, 0);
    n_cmp++;
    if (add_entry_ !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_add got %b want 1", add_entry_);
    end
    clk_step();
    n_cmp++;
    if (add_entry_ !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_add2 got %b want 1", add_entry_);
    end
    clk_step();
    drive(1, 1, 1, '0, 1, 0);
    n_cmp++;
    if (dec_iq_id !== 2'd0 || free_cnt !== 3'd4 || iq_full !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_fl got id=%0d cnt=%0d full=%b want 0/4/0",
               dec_iq_id, free_cnt, iq_full);
    end
    n_cmp++;
    if (exe_e_ !== 1'b1 || exe_iq_id !== 2'd0 || exe_payload !== '0) begin
      n_bad++;
      $display("FAIL rst_exe got e=%b id=%0d pl=%h want 1/0/0",
               exe_e_, exe_iq_id, exe_payload);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, PW'(32'hA0 + i), 1, 0);
      n_cmp++;
      if (dec_iq_id !== W'(i) || add_entry_ !== 1'b0) begin
        n_bad++;
        $display("FAIL fill_grant%0d got id=%0d add=%b want %0d/0",
                 i, dec_iq_id, add_entry_, i);
      end
      clk_step();
      n_cmp++;
      if (free_cnt !== 3'(3 - i)) begin
        n_bad++;
        $display("FAIL fill_cnt%0d got %0d want %0d", i, free_cnt, 3 - i);
      end
    end
    drive(1, 1, 0, PW'(32'hFF), 1, 0);
    n_cmp++;
    if (iq_full !== 1'b1 || add_entry_ !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_stall got full=%b add=%b want 1/1",
               iq_full, add_entry_);
    end
    clk_step();
    n_cmp++;
    if (free_cnt !== 3'd0) begin
      n_bad++;
      $display("FAIL fill_hold got %0d want 0", free_cnt);
    end
  endtask

  task automatic test_issue_wrap();
    drive(1, 1, 1, '0, 0, 2);
    clk_step();
    n_cmp++;
    if (exe_e_ !== 1'b0 || exe_iq_id !== 2'd2 || exe_payload !== PW'(32'hA2)) begin
      n_bad++;
      $display("FAIL iss2 got e=%b id=%0d pl=%h want 0/2/a2",
               exe_e_, exe_iq_id, exe_payload);
    end
    drive(1, 1, 1, '0, 0, 0);
    clk_step();
    n_cmp++;
    if (exe_iq_id !== 2'd0 || exe_payload !== PW'(32'hA0) || free_cnt !== 3'd2) begin
      n_bad++;
      $display("FAIL iss0 got id=%0d pl=%h cnt=%0d want 0/a0/2",
               exe_iq_id, exe_payload, free_cnt);
    end
    drive(1, 1, 1, '0, 1, 3);
    clk_step();
    n_cmp++;
    if (exe_e_ !== 1'b1 || exe_iq_id !== 2'd0 || exe_payload !== PW'(32'hA0)) begin
      n_bad++;
      $display("FAIL exe_hold got e=%b id=%0d pl=%h want 1/0/a0",
               exe_e_, exe_iq_id, exe_payload);
    end
    drive(1, 1, 0, PW'(32'hB2), 1, 0);
    n_cmp++;
    if (dec_iq_id !== 2'd2) begin
      n_bad++;
      $display("FAIL wrap_a got %0d want 2", dec_iq_id);
    end
    clk_step();
    drive(1, 1, 0, PW'(32'hB0), 1, 0);
    n_cmp++;
    if (dec_iq_id !== 2'd0) begin
      n_bad++;
      $display("FAIL wrap_b got %0d want 0", dec_iq_id);
    end
    clk_step();
    n_cmp++;
    if (free_cnt !== 3'd0) begin
      n_bad++;
      $display("FAIL wrap_cnt got %0d want 0", free_cnt);
    end
  endtask

  task automatic test_simul();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, PW'(32'hC0 + i), 1, 0);
      clk_step();
    end
    drive(1, 1, 0, PW'(32'h55), 0, 1);
    n_cmp++;
    if (dec_iq_id !== 2'd3 || add_entry_ !== 1'b0) begin
      n_bad++;
      $display("FAIL sim_grant got id=%0d add=%b want 3/0",
               dec_iq_id, add_entry_);
    end
    clk_step();
    n_cmp++;
    if (free_cnt !== 3'd1 || dec_iq_id !== 2'd1) begin
      n_bad++;
      $display("FAIL sim_after got cnt=%0d id=%0d want 1/1",
               free_cnt, dec_iq_id);
    end
    drive(1, 1, 0, PW'(32'h66), 1, 0);
    clk_step();
    n_cmp++;
    if (free_cnt !== 3'd0 || iq_full !== 1'b1) begin
      n_bad++;
      $display("FAIL sim_last got cnt=%0d full=%b want 0/1",
               free_cnt, iq_full);
    end
  endtask

  task automatic test_flush_illegal();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, PW'(32'hC0 + i), 1, 0);
      clk_step();
    end
    drive(1, 1, 1, '0, 0, 3);
    clk_step();
    drive(1, 0, 0, PW'(32'hDEAD), 0, 1);
    n_cmp++;
    if (add_entry_ !== 1'b1) begin
      n_bad++;
      $display("FAIL fl_add got %b want 1", add_entry_);
    end
    clk_step();
    n_cmp++;
    if (free_cnt !== 3'd4 || dec_iq_id !== 2'd0 || exe_e_ !== 1'b1) begin
      n_bad++;
      $display("FAIL fl_state got cnt=%0d id=%0d e=%b want 4/0/1",
               free_cnt, dec_iq_id, exe_e_);
    end
    n_cmp++;
    if (exe_iq_id !== 2'd3 || exe_payload !== PW'(32'hC3)) begin
      n_bad++;
      $display("FAIL fl_exe got id=%0d pl=%h want 3/c3",
               exe_iq_id, exe_payload);
    end
    drive(1, 1, 1, '0, 0, 3);
    clk_step();
    n_cmp++;
    if (free_cnt !== 3'd4 || exe_payload !== PW'(32'hC3) || exe_e_ !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf got cnt=%0d pl=%h e=%b want 4/c3/0",
               free_cnt, exe_payload, exe_e_);
    end
    drive(1, 1, 0, PW'(32'hE0), 1, 0);
    n_cmp++;
    if (dec_iq_id !== 2'd0) begin
      n_bad++;
      $display("FAIL ovf_head got %0d want 0", dec_iq_id);
    end
    clk_step();
    n_cmp++;
    if (free_cnt !== 3'd3 || dec_iq_id !== 2'd1) begin
      n_bad++;
      $display("FAIL ovf_next got cnt=%0d id=%0d want 3/1",
               free_cnt, dec_iq_id);
    end
  endtask

  task automatic test_random();
    int outs[$];
    bit found;
    logic rq, is, fl, rs;
    int iid;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      outs = {};
      for (int id = 0; id < D; id++) begin
        found = 0;
        foreach (fq[k]) if (fq[k] == id) found = 1;
        if (!found) outs.push_back(id);
      end
      rq  = ($urandom_range(0, 2) == 0);
      is  = 1'b1;
      iid = 0;
      if (outs.size() > 0 && $urandom_range(0, 2) != 0) begin
        is  = 1'b0;
        iid = outs[$urandom_range(0, outs.size() - 1)];
      end
      fl = ($urandom_range(0, 39) != 0);
      rs = ($urandom_range(0, 149) != 0);
      drive(rs, fl, rq, PW'({$urandom, $urandom}), is, iid);
      n_cmp++;
      if (add_entry_ !== exp_add_n()) begin
        n_bad++;
        $display("FAIL rnd_add c=%0d got %b want %b", c, add_entry_, exp_add_n());
      end
      if (fq.size() > 0) begin
        n_cmp++;
        if (dec_iq_id !== W'(fq[0])) begin
          n_bad++;
          $display("FAIL rnd_grant c=%0d got %0d want %0d", c, dec_iq_id, fq[0]);
        end
      end
      clk_step();
      n_cmp++;
      if (free_cnt !== 3'(fq.size()) || iq_full !== (fq.size() == 0)) begin
        n_bad++;
        $display("FAIL rnd_cnt c=%0d got %0d/%b want %0d",
                 c, free_cnt, iq_full, fq.size());
      end
      n_cmp++;
      if (exe_e_ !== me_e || exe_iq_id !== W'(me_id) || exe_payload !== me_pl) begin
        n_bad++;
        $display("FAIL rnd_exe c=%0d got %b/%0d/%h want %b/%0d/%h",
                 c, exe_e_, exe_iq_id, exe_payload, me_e, me_id, me_pl);
      end
    end
  endtask

  initial begin
    fq = {0, 1, 2, 3};
    #1;
    test_reset();
    test_fill();
    test_issue_wrap();
    test_simul();
    test_flush_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
